// File: rtl/cipher_cfg_pkg.sv
// Shared types and constants for the cipher configuration loader and cipher top.
package cipher_cfg_pkg;

    localparam int CFG_LEN = 40;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } cfg_state_e;

    // Number of write-port words needed to cover an m-bit chain.
    function automatic int calc_nb(input int m, input int w);
        return (m + w - 1) / w;
    endfunction

endpackage

// File: rtl/cipher_cfg_loader_shift_ctrl.sv
// Serial chain sequencer: walks the shadow register onto cfg_i for M cycles
// while capturing the returning chain bits from the cipher.
module cfg_shift_ctrl
    import cipher_cfg_pkg::*;
#(
    parameter int M = CFG_LEN
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift_en,
    input  logic [M-1:0] shadow,
    input  logic         cfg_ret,
    output logic         cfg_en,
    output logic         cfg_i,
    output logic         last_bit,
    output logic [M-1:0] rb_shift
);

    localparam int BW = $clog2(M);

    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [M-1:0]  rb_shift_q, rb_shift_d;

    assign cfg_en   = shift_en;
    assign cfg_i    = shift_en & shadow[bitcnt_q];
    assign last_bit = shift_en && (bitcnt_q == BW'(M - 1));
    assign rb_shift = rb_shift_q;

    always_comb begin
        bitcnt_d   = '0;
        rb_shift_d = rb_shift_q;
        if (shift_en) begin
            // The cipher's cfg_o is registered, so this cycle returns old bit bitcnt.
            rb_shift_d[bitcnt_q] = cfg_ret;
            bitcnt_d = last_bit ? '0 : bitcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt_q   <= '0;
            rb_shift_q <= '0;
        end else begin
            bitcnt_q   <= bitcnt_d;
            rb_shift_q <= rb_shift_d;
        end
    end

endmodule

// File: rtl/cipher_cfg_loader.sv
// Collects an M-bit key/seed byte-wise, shifts it into the cipher configuration
// chain and reports whether the chain returned the previously committed value.
module cipher_cfg_loader
    import cipher_cfg_pkg::*;
#(
    parameter int M = CFG_LEN,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [W-1:0] wr_data,
    input  logic         clear,
    output logic         cfg_en,
    output logic         cfg_i,
    input  logic         cfg_ret,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] rb_data,
    output logic         rb_match,
    output logic         rb_valid
);

    localparam int NB  = calc_nb(M, W);
    localparam int BCW = $clog2(NB + 1);

    cfg_state_e     state_q, state_d;
    logic [BCW-1:0] bytecnt_q, bytecnt_d;
    logic [M-1:0]   shadow_q, shadow_d;
    logic [M-1:0]   prev_commit_q, prev_commit_d;
    logic [M-1:0]   rb_data_q, rb_data_d;
    logic           rb_match_q, rb_match_d;
    logic           rb_valid_q, rb_valid_d;
    logic           commit_seen_q, commit_seen_d;
    logic           rdy_q;

    logic           shift_en;
    logic           last_bit;
    logic [M-1:0]   rb_shift;

    // rdy_q keeps wr_ready low throughout reset and releases it one edge later.
    assign wr_ready = rdy_q && (state_q == ST_IDLE);
    assign shift_en = (state_q == ST_SHIFT);
    assign busy     = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign done     = (state_q == ST_DONE);
    assign rb_data  = rb_data_q;
    assign rb_match = rb_match_q;
    assign rb_valid = rb_valid_q;

    cfg_shift_ctrl #(
        .M (M)
    ) u_shift_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .shadow   (shadow_q),
        .cfg_ret  (cfg_ret),
        .cfg_en   (cfg_en),
        .cfg_i    (cfg_i),
        .last_bit (last_bit),
        .rb_shift (rb_shift)
    );

    always_comb begin
        state_d       = state_q;
        bytecnt_d     = bytecnt_q;
        shadow_d      = shadow_q;
        prev_commit_d = prev_commit_q;
        rb_data_d     = rb_data_q;
        rb_match_d    = rb_match_q;
        rb_valid_d    = rb_valid_q;
        commit_seen_d = commit_seen_q;

        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    bytecnt_d = '0;
                end else if (wr_valid && wr_ready) begin
                    // Bits of the final word that fall beyond the chain are dropped.
                    for (int b = 0; b < W; b++) begin
                        if (int'(bytecnt_q) * W + b < M) begin
                            shadow_d[int'(bytecnt_q) * W + b] = wr_data[b];
                        end
                    end
                    bytecnt_d = bytecnt_q + 1'b1;
                    if (bytecnt_q == BCW'(NB - 1)) begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rb_data_d     = rb_shift;
                rb_match_d    = (rb_shift == prev_commit_q);
                rb_valid_d    = rb_valid_q | commit_seen_q;
                commit_seen_d = 1'b1;
                prev_commit_d = shadow_q;
                bytecnt_d     = '0;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bytecnt_q     <= '0;
            shadow_q      <= '0;
            prev_commit_q <= '0;
            rb_data_q     <= '0;
            rb_match_q    <= 1'b0;
            rb_valid_q    <= 1'b0;
            commit_seen_q <= 1'b0;
            rdy_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            bytecnt_q     <= bytecnt_d;
            shadow_q      <= shadow_d;
            prev_commit_q <= prev_commit_d;
            rb_data_q     <= rb_data_d;
            rb_match_q    <= rb_match_d;
            rb_valid_q    <= rb_valid_d;
            commit_seen_q <= commit_seen_d;
            rdy_q         <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cipher_cfg_loader.sv
// Bench for cipher_cfg_loader: a 40-bit instance with a cipher chain model and a 12-bit instance.
module tb_cipher_cfg_loader;
    import cipher_cfg_pkg::*;

    localparam int M  = 40;
    localparam int W  = 8;
    localparam int NB = 5;
    localparam int M2 = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         wr_valid, wr_ready, clear, cfg_en, cfg_i, cfg_ret, busy, done, rb_match, rb_valid;
    logic [W-1:0] wr_data;
    logic [M-1:0] rb_data;

    logic          wr_valid2, wr_ready2, clear2, cfg_en2, cfg_i2, cfg_ret2, busy2, done2, rb_match2, rb_valid2;
    logic [W-1:0]  wr_data2;
    logic [M2-1:0] rb_data2;

    int tests = 0;
    int fails = 0;

    logic [M-1:0] exp_prev;
    int           exp_loads;

    cipher_cfg_loader #(.M(M), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .clear(clear), .cfg_en(cfg_en), .cfg_i(cfg_i), .cfg_ret(cfg_ret), .busy(busy), .done(done),
        .rb_data(rb_data), .rb_match(rb_match), .rb_valid(rb_valid)
    );

    cipher_cfg_loader #(.M(M2), .W(W)) dut12 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid2), .wr_ready(wr_ready2), .wr_data(wr_data2),
        .clear(clear2), .cfg_en(cfg_en2), .cfg_i(cfg_i2), .cfg_ret(cfg_ret2), .busy(busy2), .done(done2),
        .rb_data(rb_data2), .rb_match(rb_match2), .rb_valid(rb_valid2)
    );

    // Cipher chain model: registered serial chain, bit 0 returned first; brk flips shift cycle 7.
    logic [M-1:0] chain = '0;
    int           kidx = 0;
    bit           brk = 1'b0;
    always @(posedge clk) begin
        if (cfg_en) begin
            chain <= {cfg_i, chain[M-1:1]};
            kidx  <= kidx + 1;
        end else begin
            kidx <= 0;
        end
    end
    assign cfg_ret  = chain[0] ^ (brk && kidx == 7);
    assign cfg_ret2 = 1'b0;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [W-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = d;
        while (!wr_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL send_byte_ready got=%b want=1", wr_ready);
        end
        @(posedge clk);
        #1 wr_valid = 1'b0;
    endtask

    // Full load on the 40-bit instance with all checks of shift window, done and readback.
    task automatic load40(input logic [M-1:0] val, input bit b, input string nm);
        logic [M-1:0] snap, stream, exp_rb;
        int en_cnt, first_en, last_en, done_cyc, done_cnt;
        brk  = b;
        snap = chain;
        for (int i = 0; i < NB - 1; i++) send_byte(val[i*W +: W]);
        tests++;
        if (busy !== 1'b0 || cfg_en !== 1'b0) begin
            fails++;
            $display("FAIL %s early_shift busy=%b cfg_en=%b want 0,0", nm, busy, cfg_en);
        end
        send_byte(val[(NB-1)*W +: W]);
        stream = '0; en_cnt = 0; first_en = 0; last_en = 0; done_cyc = 0; done_cnt = 0;
        for (int c = 1; c <= M + 3; c++) begin
            @(negedge clk);
            if (cfg_en) begin
                if (en_cnt < M) stream[en_cnt] = cfg_i;
                if (first_en == 0) first_en = c;
                last_en = c;
                en_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
        end
        exp_rb = snap ^ (b ? 40'h80 : 40'h0);
        tests++;
        if (en_cnt != M || first_en != 1 || last_en != M) begin
            fails++;
            $display("FAIL %s cfg_en_window count=%0d first=%0d last=%0d want %0d,1,%0d", nm, en_cnt, first_en, last_en, M, M);
        end
        tests++;
        if (stream !== val) begin
            fails++;
            $display("FAIL %s cfg_i_stream got=%h want=%h", nm, stream, val);
        end
        tests++;
        if (done_cnt != 1 || done_cyc != M + 1) begin
            fails++;
            $display("FAIL %s done_pulse count=%0d cycle=%0d want 1,%0d", nm, done_cnt, done_cyc, M + 1);
        end
        tests++;
        if (rb_data !== exp_rb) begin
            fails++;
            $display("FAIL %s rb_data got=%h want=%h", nm, rb_data, exp_rb);
        end
        tests++;
        if (rb_match !== (exp_rb == exp_prev) || rb_valid !== (exp_loads >= 1)) begin
            fails++;
            $display("FAIL %s rb_flags match=%b valid=%b want %b,%b", nm, rb_match, rb_valid,
                     (exp_rb == exp_prev), (exp_loads >= 1));
        end
        exp_prev = val;
        exp_loads++;
        brk = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({wr_ready, cfg_en, cfg_i, busy, done, rb_match, rb_valid} !== 7'b0 || rb_data !== '0) begin
            fails++;
            $display("FAIL reset_outputs got=%b/%h want 0/0",
                     {wr_ready, cfg_en, cfg_i, busy, done, rb_match, rb_valid}, rb_data);
        end
        tests++;
        if ({wr_ready2, cfg_en2, busy2, done2, rb_valid2} !== 5'b0 || rb_data2 !== '0) begin
            fails++;
            $display("FAIL reset_outputs12 got=%b/%h want 0/0", {wr_ready2, cfg_en2, busy2, done2, rb_valid2}, rb_data2);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (wr_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_before_edge got=%b want=0", wr_ready);
        end
        @(negedge clk);
        tests++;
        if (wr_ready !== 1'b1 || wr_ready2 !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_release got=%b%b want=11", wr_ready, wr_ready2);
        end
        exp_prev  = '0;
        exp_loads = 0;
    endtask

    task automatic test_basic_load();
        load40(40'h5544332211, 1'b0, "basic");
        tests++;
        if (rb_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_rb_valid got=%b want=0", rb_valid);
        end
    endtask

    task automatic test_two_loads();
        load40(40'hAABBCCDDEE, 1'b0, "second");
        tests++;
        if (rb_data !== 40'h5544332211 || rb_valid !== 1'b1 || rb_match !== 1'b1) begin
            fails++;
            $display("FAIL second_readback got=%h/%b/%b want 5544332211/1/1", rb_data, rb_valid, rb_match);
        end
        load40({8'($urandom), 32'($urandom)}, 1'b1, "broken");
        tests++;
        if (rb_data !== 40'hAABBCCDD6E || rb_match !== 1'b0) begin
            fails++;
            $display("FAIL broken_readback got=%h/%b want aabbccdd6e/0", rb_data, rb_match);
        end
    endtask

    task automatic test_random_loads();
        for (int i = 0; i < 4; i++) begin
            load40({8'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_partial();
        logic [7:0]    bytes [2];
        logic [M2-1:0] stream;
        int en_cnt, done_cyc, n;
        bytes[0] = 8'hAB;
        bytes[1] = 8'hFC;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            wr_valid2 = 1'b1;
            wr_data2  = bytes[i];
            n = 0;
            while (!wr_ready2 && n < 300) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            #1 wr_valid2 = 1'b0;
        end
        stream = '0; en_cnt = 0; done_cyc = 0;
        for (int c = 1; c <= M2 + 3; c++) begin
            @(negedge clk);
            if (cfg_en2) begin
                if (en_cnt < M2) stream[en_cnt] = cfg_i2;
                en_cnt++;
            end
            if (done2) done_cyc = c;
        end
        tests++;
        if (en_cnt != M2 || stream !== 12'hCAB) begin
            fails++;
            $display("FAIL partial_stream count=%0d bits=%h want %0d,cab", en_cnt, stream, M2);
        end
        tests++;
        if (done_cyc != M2 + 1 || rb_valid2 !== 1'b0 || rb_data2 !== '0 || rb_match2 !== 1'b1) begin
            fails++;
            $display("FAIL partial_done cycle=%0d valid=%b data=%h match=%b want %0d,0,000,1",
                     done_cyc, rb_valid2, rb_data2, rb_match2, M2 + 1);
        end
    endtask

    task automatic test_clear();
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        @(negedge clk);
        clear    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        wr_valid = 1'b0;
        tests++;
        if (busy !== 1'b0 || wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL clear_idle busy=%b ready=%b want 0,1", busy, wr_ready);
        end
        load40({8'($urandom), 32'($urandom)}, 1'b0, "after_clear");
    endtask

    task automatic test_reset_mid_shift();
        logic [M-1:0] val;
        int en_cnt;
        val = {8'($urandom), 32'($urandom)};
        for (int i = 0; i < NB; i++) send_byte(val[i*W +: W]);
        en_cnt = 0;
        for (int c = 0; c < 100 && en_cnt < 21; c++) begin
            @(negedge clk);
            if (cfg_en) en_cnt++;
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({wr_ready, cfg_en, cfg_i, busy, done, rb_match, rb_valid} !== 7'b0 || rb_data !== '0) begin
            fails++;
            $display("FAIL midshift_reset got=%b/%h want 0/0",
                     {wr_ready, cfg_en, cfg_i, busy, done, rb_match, rb_valid}, rb_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (wr_ready !== 1'b1 || cfg_en !== 1'b0) begin
            fails++;
            $display("FAIL midshift_release ready=%b cfg_en=%b want 1,0", wr_ready, cfg_en);
        end
        exp_prev  = '0;
        exp_loads = 0;
        load40({8'($urandom), 32'($urandom)}, 1'b0, "after_abort");
    endtask

    task automatic test_back_to_back();
        bit           sbits[$];
        int           gaps[$];
        int           base, nacc, gap, bad;
        logic [M-1:0] load2;
        logic [7:0]   eb;
        base = int'($urandom_range(0, 255));
        nacc = 0;
        gap  = 0;
        for (int c = 0; c < 400 && nacc < 3 * NB; c++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = 8'(base + nacc);
            if (cfg_en) sbits.push_back(cfg_i);
            if (wr_ready) begin
                if (nacc > 0 && gap > 0) gaps.push_back(gap);
                gap = 0;
                nacc++;
            end else if (nacc > 0) begin
                gap++;
            end
        end
        @(posedge clk);
        #1 wr_valid = 1'b0;
        for (int c = 0; c < M + 3; c++) begin
            @(negedge clk);
            if (cfg_en) sbits.push_back(cfg_i);
        end
        tests++;
        if (nacc != 3 * NB) begin
            fails++;
            $display("FAIL b2b_accepted got=%0d want=%0d", nacc, 3 * NB);
        end
        tests++;
        if (gaps.size() != 2 || gaps[0] != M + 1 || gaps[1] != M + 1) begin
            fails++;
            $display("FAIL b2b_ready_gap count=%0d first=%0d want 2 gaps of %0d", gaps.size(),
                     (gaps.size() > 0) ? gaps[0] : -1, M + 1);
        end
        bad = 0;
        for (int i = 0; i < 3 * M; i++) begin
            eb = 8'(base + i / 8);
            if (i >= sbits.size() || sbits[i] != eb[i % 8]) bad++;
        end
        tests++;
        if (sbits.size() != 3 * M || bad != 0) begin
            fails++;
            $display("FAIL b2b_stream bits=%0d wrong=%0d want %0d,0", sbits.size(), bad, 3 * M);
        end
        for (int i = 0; i < NB; i++) load2[i*W +: W] = 8'(base + NB + i);
        tests++;
        if (rb_data !== load2 || rb_valid !== 1'b1 || rb_match !== 1'b1) begin
            fails++;
            $display("FAIL b2b_readback got=%h/%b/%b want %h/1/1", rb_data, rb_valid, rb_match, load2);
        end
    endtask

    initial begin
        wr_valid  = 1'b0;
        wr_data   = '0;
        clear     = 1'b0;
        wr_valid2 = 1'b0;
        wr_data2  = '0;
        clear2    = 1'b0;
        test_reset();
        test_basic_load();
        test_two_loads();
        test_random_loads();
        test_partial();
        test_clear();
        test_reset_mid_shift();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
